// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
//   dmem_state_e : responder FSM states
//   dmem_req_t   : captured request (write flag, byte address, store data, byte enables)
//   WORD_BYTES   : bytes per memory word
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Backing word store for dmem_responder.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-low; clears every word, then loads PRELOAD_VAL
//            at word PRELOAD_ADDR/4
//   we     : commit strobe driven by the parent
//   idx    : word index shared by the read and write ports
//   wdata  : store data
//   be     : byte enables, bit i selects wdata[8i+7:8i]
//   rdata  : combinational read of word idx
// Each byte lane is its own array, so a byte-enabled write never touches
// the other lanes.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          PRELOAD_ADDR = 80,
  parameter logic [31:0] PRELOAD_VAL  = 32'd100,
  localparam int         IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata
);

  localparam int PRELOAD_IDX = PRELOAD_ADDR / WORD_BYTES;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      localparam logic [7:0] PRE_BYTE = PRELOAD_VAL[8*gi +: 8];

      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int w = 0; w < DEPTH_WORDS; w++) begin
            lane_mem[w] <= (w == PRELOAD_IDX) ? PRE_BYTE : 8'h00;
          end
        end else if (we && be[gi]) begin
          lane_mem[idx] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[idx];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder serving the pipeline MEM stage.
// One request is accepted at a time (req_valid/req_ready). After a fixed
// latency the response is presented (rsp_valid/rsp_ready) and held until it
// is accepted. Stores commit with byte enables; loads return the addressed
// word; misaligned or out-of-range addresses respond with rsp_err=1.
// Ports:
//   clk, reset             : clock and synchronous active-low reset
//   req_valid / req_ready  : request handshake (req_ready high only in IDLE)
//   req_write              : 1=store, 0=load
//   req_addr               : byte address
//   req_wdata / req_be     : store data and byte enables
//   rsp_valid / rsp_ready  : response handshake
//   rsp_rdata              : load data (0 for stores, errors and when idle)
//   rsp_err                : misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          LATENCY      = 2,
  parameter int          PRELOAD_ADDR = 80,
  parameter logic [31:0] PRELOAD_VAL  = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          CNT_W   = $clog2(LATENCY + 1);
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  dmem_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  dmem_req_t        req_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_rdata_reg;
  logic             rsp_err_reg;

  dmem_req_t   in_req;
  dmem_req_t   cur_req;
  logic        err_next;
  logic        enter_resp;
  logic        commit;
  logic [31:0] arr_rdata;
  logic [31:0] rdata_next;

  // With LATENCY==1 the response is formed on the accept edge itself, before
  // the request register holds the request, so in IDLE the live inputs are used.
  always_comb begin
    in_req       = '0;
    in_req.write = req_write;
    in_req.addr  = req_addr;
    in_req.wdata = req_wdata;
    in_req.be    = req_be;
    cur_req      = (state_reg == IDLE) ? in_req : req_reg;
  end

  assign err_next   = (cur_req.addr[1:0] != 2'b00) || (cur_req.addr[31:2] >= DEPTH_W);
  assign enter_resp = ((state_reg == WAIT) && (cnt_reg == CNT_W'(1))) ||
                      ((state_reg == IDLE) && req_valid && (LATENCY == 1));
  assign commit     = enter_resp && cur_req.write && !err_next;
  assign rdata_next = (cur_req.write || err_next) ? 32'h0 : arr_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .PRELOAD_ADDR(PRELOAD_ADDR),
    .PRELOAD_VAL (PRELOAD_VAL)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (commit),
    .idx  (cur_req.addr[IDX_W+1:2]),
    .wdata(cur_req.wdata),
    .be   (cur_req.be),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_reg <= in_req;
            if (LATENCY == 1) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (enter_resp) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= rdata_next;
        rsp_err_reg   <= err_next;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2, preload 100 @ 80).
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (LAT),
    .PRELOAD_ADDR(80),
    .PRELOAD_VAL (32'd100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; the request fires on the next edge and
  // the task returns just after that edge with junk left on the data inputs.
  task automatic fire_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    check("req_ready_before_fire", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'hF;
    check("req_ready_after_fire", {31'b0, req_ready}, 32'd0);
  endtask

  // Returns the number of edges from the fire edge to the first edge at
  // which rsp_valid is sampled high.
  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 50 cycles");
    end
    lat = n + 1;
  endtask

  task automatic complete_rsp(input logic [31:0] exp_rdata, input logic exp_err);
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
    check("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
    check("rsp_rdata_idle", rsp_rdata, 32'h0);
    check("rsp_err_idle", {31'b0, rsp_err}, 32'd0);
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    fire_req(w, a, d, be);
    wait_rsp(lat);
    check("latency", 32'(lat), 32'(LAT));
    complete_rsp(exp_rdata, exp_err);
    $display("txn %s addr=%h wdata=%h be=%b -> rdata=%h err=%0b lat=%0d",
             w ? "ST" : "LD", a, d, be, exp_rdata, exp_err, lat);
  endtask

  vec_t vecs [16];

  initial begin
    int lat;

    vecs[0]  = '{1'b0, 32'd80,   32'h0,         4'h0, 32'd100,       1'b0};
    vecs[1]  = '{1'b1, 32'd4,    32'd123,       4'hF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'd4,    32'h0,         4'h0, 32'd123,       1'b0};
    vecs[3]  = '{1'b1, 32'd8,    32'hAABBCCDD,  4'hF, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 32'd8,    32'h11223344,  4'h5, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'd8,    32'h0,         4'h0, 32'hAA22CC44,  1'b0};
    vecs[6]  = '{1'b0, 32'd6,    32'h0,         4'h0, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'd1024, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'd1024, 32'hDEADBEEF,  4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'd5,    32'hFFFFFFFF,  4'hF, 32'h0,         1'b1};
    vecs[10] = '{1'b1, 32'd4,    32'hFFFFFFFF,  4'h0, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'd4,    32'h0,         4'h0, 32'd123,       1'b0};
    vecs[12] = '{1'b0, 32'd0,    32'h0,         4'h0, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'd1020, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 32'd1020, 32'h12345678,  4'h8, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 32'd1020, 32'h0,         4'h0, 32'h12000000,  1'b0};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);

    // Vector table: loads, stores, byte enables, errors, top word.
    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Response back-pressure: outputs held for 5 cycles with rsp_ready low.
    fire_req(1'b0, 32'd80, 32'h0, 4'h0);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'd100);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    complete_rsp(32'd100, 1'b0);
    $display("txn LD addr=00000050 held 5 cycles -> rdata=%h", 32'd100);

    // Reset while a store sits in WAIT: nothing commits, no response appears.
    fire_req(1'b1, 32'd12, 32'h5555AAAA, 4'hF);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    $display("txn ST addr=0000000c aborted by reset");
    do_txn(1'b0, 32'd12, 32'h0, 4'h0, 32'h0, 1'b0);
    do_txn(1'b0, 32'd80, 32'h0, 4'h0, 32'd100, 1'b0);
    do_txn(1'b0, 32'd4,  32'h0, 4'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
